cpu_bus_controller: RTL
=======================

Name: cpu_bus_controller

Overview:
- Bus slave directly downstream of the RV32 multi-cycle CPU; services its request/ready word bus (rw, request, ready, address, read data, write data).
- Decodes each access to one of three targets: on-chip synchronous RAM, a handshaked peripheral port, or unmapped space.
- Returns read data and ready to the CPU; flags bus errors (unmapped access, peripheral timeout).

Parameters:
- RAM_ADDR_WIDTH, 16, RAM word-address width; RAM window is byte addresses 0 .. (4<<RAM_ADDR_WIDTH)-1 (default 256 KiB).
- RAM_READ_LATENCY, 1, cycles from RAM address presented to i_ram_rdata valid; legal range 1..4.
- PERIPH_NIBBLE, 4'h5, peripheral window is address[31:28] == PERIPH_NIBBLE.
- TIMEOUT, 255, maximum peripheral wait cycles before abort; 8-bit counter.
- UNMAPPED_DATA, 32'hDEADBEEF, read data returned for unmapped reads.

Ports:
- i_clock  in  1  system clock, all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_cpu_rw  in  1  0 = read, 1 = write.
- i_cpu_request  in  1  access request, held by CPU until it samples ready.
- o_cpu_ready  out  1  access complete; held until request sampled low.
- i_cpu_address  in  32  byte address; bits [1:0] ignored.
- i_cpu_data  in  32  write data from CPU.
- o_cpu_data  out  32  read data to CPU, valid while o_cpu_ready high.
- o_ram_address  out  RAM_ADDR_WIDTH  RAM word address.
- o_ram_we  out  1  RAM write enable, single-cycle pulse.
- o_ram_wdata  out  32  RAM write data.
- i_ram_rdata  in  32  RAM read data.
- o_per_request  out  1  peripheral request.
- o_per_rw  out  1  peripheral direction.
- o_per_address  out  28  peripheral offset, address[27:0].
- o_per_wdata  out  32  peripheral write data.
- i_per_ready  in  1  peripheral completion.
- i_per_rdata  in  32  peripheral read data, valid with i_per_ready.
- o_bus_error  out  1  sticky error flag.
- o_error_address  out  32  address of the first erroring access.

Behaviour:
- Async reset, active-low: every output = 0, state IDLE, counters = 0. This is immediate and abandons any in-flight access, so o_per_request drops asynchronously.
- States: IDLE, RAM_WAIT, PER_WAIT, RESPOND.
- IDLE: when i_cpu_request is sampled high at edge k, latch rw/address/data and decode. RAM is address[31:RAM_ADDR_WIDTH+2] == 0. Peripheral is address[31:28] == PERIPH_NIBBLE. Anything else is unmapped.
- RAM read: at k, o_ram_address = address[RAM_ADDR_WIDTH+1:2] and state goes to RAM_WAIT. At k+RAM_READ_LATENCY+1, o_cpu_data <= i_ram_rdata, o_cpu_ready <= 1, and state goes to RESPOND.
- RAM write: at k, o_ram_we <= 1 and o_ram_wdata <= data. At k+1, o_ram_we <= 0, o_cpu_ready <= 1, and state goes to RESPOND. o_ram_we is high for exactly one cycle.
- Peripheral: at k, o_per_request/rw/address/wdata are driven and state goes to PER_WAIT with the wait counter cleared. On the first edge where i_per_ready is sampled high:
  - o_per_request <= 0.
  - o_cpu_data <= i_per_rdata for reads, 0 for writes.
  - o_cpu_ready <= 1, state goes to RESPOND.
- Peripheral timeout: the counter increments on each PER_WAIT edge without i_per_ready. When it reaches TIMEOUT:
  - o_per_request <= 0, o_cpu_data <= 0, o_cpu_ready <= 1.
  - Error is recorded, state goes to RESPOND.
  - If i_per_ready and the timeout coincide on the same edge, ready wins and no error is recorded.
- Unmapped: at k+1, o_cpu_ready <= 1. o_cpu_data = UNMAPPED_DATA for reads, 0 for writes. Writes are discarded. Error is recorded.
- Error record: o_bus_error is set and stays set until reset. o_error_address is loaded only if o_bus_error was previously 0, so the first error is kept.
- RESPOND: o_cpu_ready and o_cpu_data are held stable. On the edge where i_cpu_request is sampled low, o_cpu_ready <= 0 and state goes to IDLE. A new request is accepted only from IDLE.
- Protocol: the CPU drops its request on the edge it samples ready, so ready is high for 2 cycles per access.
- A request withdrawn before ready still completes the access. Ready is then high for 1 cycle.
- Target outputs other than the request and write-enable strobes hold their last values when idle.

Test Plan:
- Reset, then CPU read of 0x0000_0200 with RAM returning 0x00000013 (RAM_READ_LATENCY=1) -> o_ram_address=0x80; ready and o_cpu_data=0x00000013 at k+2; ready low one edge after request drops.
- CPU write 0x12345678 to 0x0002_7FFC -> o_ram_we high one cycle with o_ram_address=0x9FFF and o_ram_wdata=0x12345678; ready at k+1.
- Peripheral read of 0x5000_0010, with i_per_ready after 3 cycles and data 0xA5 -> o_per_address=0x0000010; o_per_request held 3 cycles; o_cpu_data=0xA5; o_bus_error stays 0.
- Peripheral write with i_per_ready never asserted, TIMEOUT=4 -> request drops after 4 wait cycles; ready with data 0; o_bus_error=1; o_error_address=access address.
- Unmapped read of 0x8000_0000 followed by unmapped read of 0x9000_0000 -> o_cpu_data=0xDEADBEEF both times; o_error_address stays 0x8000_0000.
- Assert i_reset_n low mid-PER_WAIT -> o_per_request, o_cpu_ready and o_bus_error go 0 immediately without a clock edge; next request is serviced normally.

Source files
------------

// File: rtl/cpu_bus_controller.sv
// Word-bus slave for the RV32 multi-cycle CPU: routes each access to on-chip RAM, a handshaked
// peripheral port or unmapped space, and keeps a sticky record of the first bus error.
module cpu_bus_controller #(
    parameter int unsigned RAM_ADDR_WIDTH   = 16,
    parameter int unsigned RAM_READ_LATENCY = 1,
    parameter logic [3:0]  PERIPH_NIBBLE    = 4'h5,
    parameter int unsigned TIMEOUT          = 255,
    parameter logic [31:0] UNMAPPED_DATA    = 32'hDEADBEEF
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_cpu_rw,
    input  logic                      i_cpu_request,
    output logic                      o_cpu_ready,
    input  logic [31:0]               i_cpu_address,
    input  logic [31:0]               i_cpu_data,
    output logic [31:0]               o_cpu_data,
    output logic [RAM_ADDR_WIDTH-1:0] o_ram_address,
    output logic                      o_ram_we,
    output logic [31:0]               o_ram_wdata,
    input  logic [31:0]               i_ram_rdata,
    output logic                      o_per_request,
    output logic                      o_per_rw,
    output logic [27:0]               o_per_address,
    output logic [31:0]               o_per_wdata,
    input  logic                      i_per_ready,
    input  logic [31:0]               i_per_rdata,
    output logic                      o_bus_error,
    output logic [31:0]               o_error_address
);

    localparam logic [7:0] RamLatency  = 8'(RAM_READ_LATENCY);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRamWait, StPerWait, StRespond} state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    logic                      r_rw;
    logic                      r_is_ram;
    logic [31:0]               r_address;
    logic [7:0]                r_count;
    logic                      r_cpu_ready;
    logic [31:0]               r_cpu_data;
    logic [RAM_ADDR_WIDTH-1:0] r_ram_address;
    logic                      r_ram_we;
    logic [31:0]               r_ram_wdata;
    logic                      r_per_request;
    logic                      r_per_rw;
    logic [27:0]               r_per_address;
    logic [31:0]               r_per_wdata;
    logic                      r_bus_error;
    logic [31:0]               r_error_address;

    logic w_is_ram;
    logic w_is_per;
    logic w_ram_done;
    logic w_timeout;
    logic w_record_error;

    assign w_is_ram = (i_cpu_address >> (RAM_ADDR_WIDTH + 2)) == 32'd0;
    assign w_is_per = !w_is_ram && (i_cpu_address[31:28] == PERIPH_NIBBLE);

    // RAM_WAIT also carries unmapped accesses, which complete one edge after acceptance.
    assign w_ram_done     = !r_is_ram || r_rw || (r_count == RamLatency);
    assign w_timeout      = !i_per_ready && (r_count == TimeoutLast);
    assign w_record_error = ((r_state == StRamWait) && !r_is_ram) ||
                            ((r_state == StPerWait) && w_timeout);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_cpu_request) begin
                    w_state_next = w_is_per ? StPerWait : StRamWait;
                end
            end
            StRamWait: begin
                if (w_ram_done) begin
                    w_state_next = StRespond;
                end
            end
            StPerWait: begin
                if (i_per_ready || w_timeout) begin
                    w_state_next = StRespond;
                end
            end
            StRespond: begin
                if (!i_cpu_request) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rw            <= 1'b0;
            r_is_ram        <= 1'b0;
            r_address       <= '0;
            r_count         <= '0;
            r_cpu_ready     <= 1'b0;
            r_cpu_data      <= '0;
            r_ram_address   <= '0;
            r_ram_we        <= 1'b0;
            r_ram_wdata     <= '0;
            r_per_request   <= 1'b0;
            r_per_rw        <= 1'b0;
            r_per_address   <= '0;
            r_per_wdata     <= '0;
            r_bus_error     <= 1'b0;
            r_error_address <= '0;
        end else begin
            r_ram_we <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_cpu_request) begin
                        r_rw      <= i_cpu_rw;
                        r_is_ram  <= w_is_ram;
                        r_address <= i_cpu_address;
                        r_count   <= '0;
                        if (w_is_ram) begin
                            r_ram_address <= i_cpu_address[RAM_ADDR_WIDTH+1:2];
                            if (i_cpu_rw) begin
                                r_ram_we    <= 1'b1;
                                r_ram_wdata <= i_cpu_data;
                            end
                        end else if (w_is_per) begin
                            r_per_request <= 1'b1;
                            r_per_rw      <= i_cpu_rw;
                            r_per_address <= i_cpu_address[27:0];
                            r_per_wdata   <= i_cpu_data;
                        end
                    end
                end
                StRamWait: begin
                    r_count <= r_count + 8'd1;
                    if (w_ram_done) begin
                        r_cpu_ready <= 1'b1;
                        if (r_rw) begin
                            r_cpu_data <= '0;
                        end else if (r_is_ram) begin
                            r_cpu_data <= i_ram_rdata;
                        end else begin
                            r_cpu_data <= UNMAPPED_DATA;
                        end
                    end
                end
                StPerWait: begin
                    if (i_per_ready || w_timeout) begin
                        r_per_request <= 1'b0;
                        r_cpu_ready   <= 1'b1;
                        r_cpu_data    <= (i_per_ready && !r_rw) ? i_per_rdata : 32'd0;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                StRespond: begin
                    if (!i_cpu_request) begin
                        r_cpu_ready <= 1'b0;
                    end
                end
            endcase
            // Only the first error since reset is captured.
            if (w_record_error) begin
                r_bus_error <= 1'b1;
                if (!r_bus_error) begin
                    r_error_address <= r_address;
                end
            end
        end
    end

    assign o_cpu_ready     = r_cpu_ready;
    assign o_cpu_data      = r_cpu_data;
    assign o_ram_address   = r_ram_address;
    assign o_ram_we        = r_ram_we;
    assign o_ram_wdata     = r_ram_wdata;
    assign o_per_request   = r_per_request;
    assign o_per_rw        = r_per_rw;
    assign o_per_address   = r_per_address;
    assign o_per_wdata     = r_per_wdata;
    assign o_bus_error     = r_bus_error;
    assign o_error_address = r_error_address;

endmodule
